// File: rtl/cla_carry_dist_pipe_if.sv
// Operand/result stream bundle for the pipelined carry-lookahead adder.
// slave: the adder side; master: the producer/consumer side.
interface cla_carry_dist_pipe_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             g_out;
  logic             p_out;
  logic             ovf;

  modport slave (
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, g_out, p_out, ovf
  );

  modport master (
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, g_out, p_out, ovf
  );
endinterface

// File: rtl/cla_carry_dist_pipe.sv
// Two-stage pipelined carry-lookahead adder with valid/ready flow control.
// Stage 1 collapses bit g/p into per-block G/P; stage 2 distributes carries
// from c_in down to every block and bit and registers the sum and flags.
// WIDTH must be a multiple of GROUP.
module cla_carry_dist_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned GROUP = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cla_carry_dist_pipe_if.slave  bus
);

  localparam int unsigned NB = WIDTH / GROUP;

  // stage 1 state
  logic             s1_valid;
  logic [WIDTH-1:0] s1_p;
  logic [WIDTH-1:0] s1_g;
  logic [NB-1:0]    s1_bg;
  logic [NB-1:0]    s1_bp;
  logic             s1_cin;

  // stage 2 state (drives the outputs directly)
  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             c_out_q;
  logic             g_out_q;
  logic             p_out_q;
  logic             ovf_q;

  // flow control
  logic s2_ready;
  logic in_ready;
  logic accept;

  // stage 1 next values
  logic [WIDTH-1:0] p_n;
  logic [WIDTH-1:0] g_n;
  logic [NB-1:0]    bg_n;
  logic [NB-1:0]    bp_n;
  logic             grp_g;
  logic             grp_p;

  // stage 2 next values
  logic [WIDTH-1:0] sum_n;
  logic             blk_c;
  logic             bit_c;
  logic             msb_c;
  logic             word_g;
  logic             word_p;

  assign s2_ready = !out_valid_q || bus.out_ready;
  assign in_ready = !s1_valid || s2_ready;
  assign accept   = bus.in_valid && in_ready;

  // Bit generate/propagate and their upward collapse into block G/P.
  always_comb begin
    p_n   = bus.a ^ bus.b;
    g_n   = bus.a & bus.b;
    bg_n  = '0;
    bp_n  = '0;
    grp_g = 1'b0;
    grp_p = 1'b1;
    for (int j = 0; j < NB; j++) begin
      grp_g = 1'b0;
      grp_p = 1'b1;
      for (int k = 0; k < GROUP; k++) begin
        grp_g = g_n[j*GROUP+k] | (p_n[j*GROUP+k] & grp_g);
        grp_p = grp_p & p_n[j*GROUP+k];
      end
      bg_n[j] = grp_g;
      bp_n[j] = grp_p;
    end
  end

  // Carry distribution: block carries from block G/P, bit carries inside each block.
  always_comb begin
    sum_n  = '0;
    blk_c  = s1_cin;
    bit_c  = 1'b0;
    msb_c  = 1'b0;
    word_g = 1'b0;
    word_p = 1'b1;
    for (int j = 0; j < NB; j++) begin
      bit_c = blk_c;
      for (int k = 0; k < GROUP; k++) begin
        sum_n[j*GROUP+k] = s1_p[j*GROUP+k] ^ bit_c;
        msb_c            = bit_c;
        bit_c            = s1_g[j*GROUP+k] | (s1_p[j*GROUP+k] & bit_c);
      end
      blk_c  = s1_bg[j] | (s1_bp[j] & blk_c);
      word_g = s1_bg[j] | (s1_bp[j] & word_g);
      word_p = word_p & s1_bp[j];
    end
  end

  // Stage 1 register: captures a beat whenever the stage can accept one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_p     <= '0;
      s1_g     <= '0;
      s1_bg    <= '0;
      s1_bp    <= '0;
      s1_cin   <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid <= bus.in_valid;
      end
      if (accept) begin
        s1_p   <= p_n;
        s1_g   <= g_n;
        s1_bg  <= bg_n;
        s1_bp  <= bp_n;
        s1_cin <= bus.c_in;
      end
    end
  end

  // Stage 2 register: advances on s2_ready, otherwise holds the result bit-exact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      c_out_q     <= 1'b0;
      g_out_q     <= 1'b0;
      p_out_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (s2_ready) begin
      out_valid_q <= s1_valid;
      if (s1_valid) begin
        sum_q   <= sum_n;
        c_out_q <= blk_c;
        g_out_q <= word_g;
        p_out_q <= word_p;
        ovf_q   <= msb_c ^ blk_c;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.c_out     = c_out_q;
  assign bus.g_out     = g_out_q;
  assign bus.p_out     = p_out_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_cla_carry_dist_pipe.sv
// Self-checking bench for cla_carry_dist_pipe (WIDTH=16, GROUP=4).
// Inputs are driven just after the falling edge; outputs are checked 1ns later.
module tb_cla_carry_dist_pipe;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned GROUP = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  cla_carry_dist_pipe_if #(.WIDTH(WIDTH)) bus ();

  cla_carry_dist_pipe #(.WIDTH(WIDTH), .GROUP(GROUP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // expected results in acceptance order: {ovf, p_out, g_out, c_out, sum}
  logic [19:0] exp_q[$];
  int          acc_cyc_q[$];

  logic [15:0] last_sum;
  logic        last_c_out, last_g_out, last_p_out, last_ovf, last_ov;
  int          last_lat;

  logic        acc;
  int          n_acc;
  logic [15:0] pa, pb;
  logic        pc;
  logic [15:0] bp_a[5];
  logic [15:0] bp_b[5];
  logic        acc_hist[40];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: plain integer addition and sign-rule overflow.
  function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b, input logic cin);
    logic [16:0] ab;
    logic [16:0] full;
    logic        ov;
    ab   = {1'b0, a} + {1'b0, b};
    full = ab + 17'(cin);
    ov   = (a[15] == b[15]) && (full[15] != a[15]);
    return {ov, &(a ^ b), ab[16], full};
  endfunction

  // One clock cycle: drive, check the head of the scoreboard, advance.
  task automatic cycle(input logic iv, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic ordy, output logic accepted);
    logic [19:0] e;
    logic        ov;
    bus.in_valid  = iv;
    bus.a         = a;
    bus.b         = b;
    bus.c_in      = cin;
    bus.out_ready = ordy;
    #1;
    ov       = bus.out_valid;
    last_ov  = ov;
    accepted = iv & bus.in_ready;
    if (ov) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", 32'(ov), 32'd0);
      end else begin
        e = exp_q[0];
        chk("sum",   32'(bus.sum),   32'(e[15:0]));
        chk("c_out", 32'(bus.c_out), 32'(e[16]));
        chk("g_out", 32'(bus.g_out), 32'(e[17]));
        chk("p_out", 32'(bus.p_out), 32'(e[18]));
        chk("ovf",   32'(bus.ovf),   32'(e[19]));
        if (ordy) begin
          last_sum   = bus.sum;
          last_c_out = bus.c_out;
          last_g_out = bus.g_out;
          last_p_out = bus.p_out;
          last_ovf   = bus.ovf;
          last_lat   = cyc - acc_cyc_q.pop_front();
          void'(exp_q.pop_front());
        end
      end
    end
    if (accepted) begin
      exp_q.push_back(model(a, b, cin));
      acc_cyc_q.push_back(cyc);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  // Single beat through an empty pipe, result compared against fixed values.
  task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic [15:0] esum, input logic ec, input logic eg,
                          input logic ep, input logic eo);
    logic a_ok;
    a_ok = 1'b0;
    for (int i = 0; i < 10 && !a_ok; i++) cycle(1'b1, a, b, cin, 1'b1, a_ok);
    chk({tag, "_accept"}, 32'(a_ok), 32'd1);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);
    chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_sum"},   32'(last_sum),   32'(esum));
    chk({tag, "_cout"},  32'(last_c_out), 32'(ec));
    chk({tag, "_gout"},  32'(last_g_out), 32'(eg));
    chk({tag, "_pout"},  32'(last_p_out), 32'(ep));
    chk({tag, "_ovf"},   32'(last_ovf),   32'(eo));
    chk({tag, "_latency"}, 32'(last_lat), 32'd2);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.c_in      = 1'b0;
    bus.out_ready = 1'b0;
    last_ov       = 1'b0;

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_sum",       32'(bus.sum),       32'd0);
    chk("rst_c_out",     32'(bus.c_out),     32'd0);
    chk("rst_g_out",     32'(bus.g_out),     32'd0);
    chk("rst_p_out",     32'(bus.p_out),     32'd0);
    chk("rst_ovf",       32'(bus.ovf),       32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // full carry ripple and signed overflow corners
    directed("ripple", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    directed("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b1);
    directed("ovf_neg", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1);

    // back-pressure: 5 beats offered, consumer stalled for 4 cycles
    for (int i = 0; i < 5; i++) begin
      bp_a[i] = 16'($urandom);
      bp_b[i] = 16'($urandom);
    end
    n_acc = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, bp_a[n_acc], bp_b[n_acc], 1'(i), 1'b0, acc);
      if (i >= 2) chk("bp_in_ready_low", 32'(acc), 32'd0);
      if (acc) n_acc++;
    end
    chk("bp_accepted_during_stall", 32'(n_acc), 32'd2);
    for (int i = 0; i < 50 && (n_acc < 5 || exp_q.size() != 0); i++) begin
      cycle(n_acc < 5, bp_a[n_acc % 5], bp_b[n_acc % 5], 1'b1, 1'b1, acc);
      if (acc) n_acc++;
    end
    chk("bp_all_accepted", 32'(n_acc), 32'd5);
    chk("bp_all_drained", 32'(exp_q.size()), 32'd0);

    // streaming: random operands at full rate, random consumer readiness
    n_acc = 0;
    pa = 16'($urandom);
    pb = 16'($urandom);
    pc = 1'($urandom);
    for (int i = 0; i < 5000 && n_acc < 1000; i++) begin
      cycle(1'b1, pa, pb, pc, 1'($urandom_range(0, 1)), acc);
      if (acc) begin
        n_acc++;
        pa = 16'($urandom);
        case ($urandom_range(0, 3))
          0:       pb = ~pa;
          1:       pb = 16'h8000;
          default: pb = 16'($urandom);
        endcase
        pc = 1'($urandom);
      end
    end
    chk("stream_accepted", 32'(n_acc), 32'd1000);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);
    chk("stream_drained", 32'(exp_q.size()), 32'd0);

    // bubbles: one beat every third cycle, output pulse two cycles after accept
    for (int t = 0; t < 40; t++) begin
      cycle((t % 3) == 0, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1, acc);
      acc_hist[t] = acc;
      if (t % 3 == 0) chk("bubble_accept", 32'(acc), 32'd1);
      chk("bubble_out_valid", 32'(last_ov), (t >= 2) ? 32'(acc_hist[t-2]) : 32'd0);
    end
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);
    chk("bubble_drained", 32'(exp_q.size()), 32'd0);

    // reset mid-operation with two beats in flight
    cycle(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0, acc);
    cycle(1'b1, 16'hABCD, 16'h1111, 1'b1, 1'b0, acc);
    bus.in_valid = 1'b0;
    #1;
    chk("inflight_out_valid", 32'(bus.out_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_sum",       32'(bus.sum),       32'd0);
    chk("midrst_c_out",     32'(bus.c_out),     32'd0);
    chk("midrst_g_out",     32'(bus.g_out),     32'd0);
    chk("midrst_p_out",     32'(bus.p_out),     32'd0);
    chk("midrst_ovf",       32'(bus.ovf),       32'd0);
    exp_q.delete();
    acc_cyc_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b1, acc);
      chk("post_rst_out_valid", 32'(last_ov), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
